// File: rtl/cordic_prerot_if.sv
// Sample channel of the CORDIC pre-rotation stage: input and output
// valid/ready handshakes together with their payload fields.
interface cordic_prerot_if #(
    parameter int W  = 16,
    parameter int G  = 2,
    parameter int TW = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [W-1:0]   in_x;
    logic signed [W-1:0]   in_y;
    logic signed [W-1:0]   in_z;
    logic                  in_mode;
    logic [TW-1:0]         in_tag;

    logic                  out_valid;
    logic                  out_ready;
    logic signed [W+G-1:0] out_x;
    logic signed [W+G-1:0] out_y;
    logic signed [W-1:0]   out_z;
    logic                  out_mode;
    logic [1:0]            out_quad;
    logic [TW-1:0]         out_tag;

    // Environment side: produces input samples and consumes folded samples.
    modport master (
        output in_valid, in_x, in_y, in_z, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_z, out_mode, out_quad, out_tag
    );

    // Block side.
    modport slave (
        input  in_valid, in_x, in_y, in_z, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_x, out_y, out_z, out_mode, out_quad, out_tag
    );
endinterface

// File: rtl/cordic_prerot.sv
// Two-stage CORDIC pre-rotation: folds each sample into the convergence range
// (|z| <= pi/2 in rotation mode, x >= 0 in vector mode) with valid/ready flow control.
module cordic_prerot #(
    parameter int W  = 16,
    parameter int G  = 2,
    parameter int TW = 4,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst,
    cordic_prerot_if.slave   bus,
    input  logic             cnt_clr,
    output logic [CW-1:0]    fold_cnt
);

    if (G < 1) begin : g_bad_guard
        $error("cordic_prerot: G must be >= 1");
    end
    if (W < 3) begin : g_bad_width
        $error("cordic_prerot: W must be >= 3");
    end
    if (CW < 1) begin : g_bad_cnt
        $error("cordic_prerot: CW must be >= 1");
    end

    typedef enum logic [1:0] {
        Q_NONE = 2'b00,
        Q_POS  = 2'b01,
        Q_NEG  = 2'b10,
        Q_PI   = 2'b11
    } quad_t;

    localparam logic signed [W-1:0] HALF_PI     = {2'b01, {(W-2){1'b0}}};
    localparam logic signed [W-1:0] NEG_HALF_PI = {2'b11, {(W-2){1'b0}}};

    // Stage 1 (capture and classify)
    logic                s1_valid;
    logic signed [W-1:0] s1_x;
    logic signed [W-1:0] s1_y;
    logic signed [W-1:0] s1_z;
    logic                s1_mode;
    logic [TW-1:0]       s1_tag;
    quad_t               s1_quad;

    logic  adv1;
    logic  adv2;
    quad_t in_quad;

    logic signed [W+G-1:0] x_ext;
    logic signed [W+G-1:0] y_ext;
    logic signed [W+G-1:0] fx;
    logic signed [W+G-1:0] fy;
    logic signed [W-1:0]   fz;

    assign adv2         = !bus.out_valid || bus.out_ready;
    assign adv1         = !s1_valid || adv2;
    assign bus.in_ready = adv1;

    always_comb begin
        in_quad = Q_NONE;
        if (!bus.in_mode) begin
            if (bus.in_z > HALF_PI) begin
                in_quad = Q_POS;
            end else if (bus.in_z < NEG_HALF_PI) begin
                in_quad = Q_NEG;
            end
        end else if (bus.in_x[W-1]) begin
            in_quad = Q_PI;
        end
    end

    // Guard bits make the negation of the most negative input exact.
    always_comb begin
        x_ext = {{G{s1_x[W-1]}}, s1_x};
        y_ext = {{G{s1_y[W-1]}}, s1_y};
        fx    = x_ext;
        fy    = y_ext;
        fz    = s1_z;
        case (s1_quad)
            Q_POS: begin
                fx = -y_ext;
                fy = x_ext;
                fz = s1_z - HALF_PI;
            end
            Q_NEG: begin
                fx = y_ext;
                fy = -x_ext;
                fz = s1_z + HALF_PI;
            end
            Q_PI: begin
                fx = -x_ext;
                fy = -y_ext;
                fz = {~s1_z[W-1], s1_z[W-2:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_x         <= '0;
            s1_y         <= '0;
            s1_z         <= '0;
            s1_mode      <= 1'b0;
            s1_tag       <= '0;
            s1_quad      <= Q_NONE;
            bus.out_valid <= 1'b0;
            bus.out_x    <= '0;
            bus.out_y    <= '0;
            bus.out_z    <= '0;
            bus.out_mode <= 1'b0;
            bus.out_quad <= '0;
            bus.out_tag  <= '0;
        end else begin
            if (adv2) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_x    <= fx;
                    bus.out_y    <= fy;
                    bus.out_z    <= fz;
                    bus.out_mode <= s1_mode;
                    bus.out_quad <= s1_quad;
                    bus.out_tag  <= s1_tag;
                end
            end
            if (adv1) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_x    <= bus.in_x;
                    s1_y    <= bus.in_y;
                    s1_z    <= bus.in_z;
                    s1_mode <= bus.in_mode;
                    s1_tag  <= bus.in_tag;
                    s1_quad <= in_quad;
                end
            end
        end
    end

    // Clear wins over a simultaneous qualifying transfer.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            fold_cnt <= '0;
        end else if (bus.out_valid && bus.out_ready && (bus.out_quad != 2'b00)
                     && (fold_cnt != '1)) begin
            fold_cnt <= fold_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_cordic_prerot.sv
// Directed bench for cordic_prerot: fold arithmetic, boundaries, backpressure,
// mid-stream reset and fold counter saturation/clear.
module tb_cordic_prerot;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cnt_clr  = 1'b0;
    logic cnt_clr2 = 1'b0;
    logic [15:0] fold_cnt;
    logic [2:0]  fold_cnt2;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    int  sent, rcvd, occ;
    logic ix, ox;

    always #5 clk = ~clk;

    cordic_prerot_if #(.W(16), .G(2), .TW(4)) bus  ();
    cordic_prerot_if #(.W(16), .G(2), .TW(4)) bus2 ();

    cordic_prerot #(.W(16), .G(2), .TW(4), .CW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cnt_clr  (cnt_clr),
        .fold_cnt (fold_cnt)
    );

    cordic_prerot #(.W(16), .G(2), .TW(4), .CW(3)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus2),
        .cnt_clr  (cnt_clr2),
        .fold_cnt (fold_cnt2)
    );

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string nm, input logic mode, input int x, input int y,
                           input int z, input int ex, input int ey, input int ez,
                           input int eq, input int tg);
        bus.in_valid = 1'b1;
        bus.in_mode  = mode;
        bus.in_x     = 16'(x);
        bus.in_y     = 16'(y);
        bus.in_z     = 16'(z);
        bus.in_tag   = 4'(tg);
        tick();
        bus.in_valid = 1'b0;
        tick();
        check({nm, ".valid"}, bus.out_valid, 1);
        check({nm, ".x"},     bus.out_x, ex);
        check({nm, ".y"},     bus.out_y, ey);
        check({nm, ".z"},     bus.out_z, ez);
        check({nm, ".quad"},  bus.out_quad, eq);
        check({nm, ".mode"},  bus.out_mode, mode);
        check({nm, ".tag"},   bus.out_tag, tg);
        if (eq != 0) exp_cnt++;
        tick();
        check({nm, ".cnt"},   fold_cnt, exp_cnt);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_z      = '0;
        bus.in_mode   = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.in_x      = 16'sd1000;
        bus2.in_y      = 16'sd200;
        bus2.in_z      = 16'sd20000;
        bus2.in_mode   = 1'b0;
        bus2.in_tag    = '0;
        bus2.out_ready = 1'b1;

        repeat (3) tick();
        rst = 1'b0;
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.out_x",     bus.out_x, 0);
        check("rst.out_quad",  bus.out_quad, 0);
        check("rst.fold_cnt",  fold_cnt, 0);
        check("rst.in_ready",  bus.in_ready, 1);

        //       name     mode  x       y       z       ex      ey      ez      q  tag
        run_vec("rot_pos",  0,  1000,   200,    20000, -200,   1000,   3616,   1, 1);
        run_vec("rot_neg",  0,  1000,   200,   -20000,  200,  -1000,  -3616,   2, 2);
        run_vec("rot_pp",   0,  1000,   200,    16384,  1000,   200,   16384,  0, 3);
        run_vec("rot_mp",   0,  1000,   200,   -16384,  1000,   200,  -16384,  0, 4);
        run_vec("rot_min",  0,  1000,   200,   -32768,  200,  -1000,  -16384,  2, 5);
        run_vec("rot_max",  0,  -5,     3,      32767, -3,     -5,     16383,  1, 6);
        run_vec("vec_neg",  1,  -100,   50,     0,      100,   -50,   -32768,  3, 7);
        run_vec("vec_min",  1, -32768, -32768,  5,      32768,  32768, -32763, 3, 8);
        run_vec("vec_zero", 1,  0,     -7,      100,    0,     -7,     100,    0, 9);

        // Backpressure stream with pseudo-random out_ready.
        sent = 0; rcvd = 0; occ = 0;
        for (int cyc = 0; cyc < 300 && rcvd < 8; cyc++) begin
            bus.in_valid  = (sent < 8);
            bus.in_mode   = 1'b0;
            bus.in_tag    = 4'(sent);
            bus.in_x      = 16'(sent * 10);
            bus.in_y      = '0;
            bus.in_z      = '0;
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            check("bp.in_ready", bus.in_ready, !(occ == 2 && !bus.out_ready));
            ix = bus.in_valid && bus.in_ready;
            ox = bus.out_valid && bus.out_ready;
            if (ox) begin
                check("bp.tag", bus.out_tag, rcvd);
                check("bp.x",   bus.out_x, rcvd * 10);
                rcvd++;
            end
            if (ix) sent++;
            occ = occ + int'(ix) - int'(ox);
            @(posedge clk);
            #1;
        end
        check("bp.received", rcvd, 8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp.drained", bus.out_valid, 0);

        // Two folded samples in flight, then reset.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_x      = 16'sd1000;
        bus.in_y      = 16'sd200;
        bus.in_z      = 16'sd20000;
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("mid.full", bus.in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("mid.out_valid", bus.out_valid, 0);
        check("mid.fold_cnt",  fold_cnt, 0);
        check("mid.in_ready",  bus.in_ready, 1);
        exp_cnt = 0;
        tick();
        check("mid.no_output", bus.out_valid, 0);
        run_vec("post_rst", 0, 1000, 200, 20000, -200, 1000, 3616, 1, 10);

        // Saturation of a 3-bit fold counter.
        bus2.in_valid = 1'b1;
        repeat (9) tick();
        bus2.in_valid = 1'b0;
        repeat (3) tick();
        check("sat.cnt", fold_cnt2, 7);
        bus2.in_valid = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        tick();
        check("clr.out_valid", bus2.out_valid, 1);
        cnt_clr2 = 1'b1;
        tick();
        cnt_clr2 = 1'b0;
        check("clr.cnt", fold_cnt2, 0);
        bus2.in_valid = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        repeat (2) tick();
        check("clr.recount", fold_cnt2, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
